// File: rtl/hdlc_tx_framer.sv
// Bit-serial HDLC transmit framer: flags, LSB-first zero-stuffed payload,
// abort/underrun/overflow termination and a minimum idle gap between frames.
module hdlc_tx_framer #(
    parameter int MAX_FRAME_BYTES = 126,
    parameter int IDLE_BITS       = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxEN,
    input  logic       Tx_Start,
    input  logic       Tx_Valid,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Last,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_RdBuff,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Underrun,
    output logic       Tx_Overflow,
    output logic [7:0] Tx_ByteCount
);

    typedef enum logic [2:0] {
        IDLE,
        OPEN_FLAG,
        DATA,
        CLOSE_FLAG,
        ABORT,
        GAP
    } state_t;

    localparam int GW = $clog2(IDLE_BITS + 1);
    // Line order is LSB first: flag 0111_1110, abort 0111_1111.
    localparam logic [7:0] FLAG_PAT  = 8'h7E;
    localparam logic [7:0] ABORT_PAT = 8'hFE;

    state_t        state;
    logic [7:0]    shReg;
    logic [3:0]    bitCnt;
    logic [2:0]    onesCnt;
    logic          isLast;
    logic [GW-1:0] gapCnt;
    logic          abortReq;

    assign abortReq = Tx_AbortFrame || !TxEN;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            shReg           <= '0;
            bitCnt          <= '0;
            onesCnt         <= '0;
            isLast          <= 1'b0;
            gapCnt          <= '0;
            Tx              <= 1'b1;
            Tx_RdBuff       <= 1'b0;
            Tx_Busy         <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Underrun     <= 1'b0;
            Tx_Overflow     <= 1'b0;
            Tx_ByteCount    <= '0;
        end else begin
            Tx_RdBuff       <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Underrun     <= 1'b0;
            Tx_Overflow     <= 1'b0;
            unique case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (Tx_Start && TxEN && Tx_Valid) begin
                        shReg        <= Tx_Data;
                        isLast       <= Tx_Last;
                        Tx_RdBuff    <= 1'b1;
                        Tx_ByteCount <= 8'd1;
                        Tx_Busy      <= 1'b1;
                        bitCnt       <= '0;
                        onesCnt      <= '0;
                        state        <= OPEN_FLAG;
                    end
                end
                OPEN_FLAG: begin
                    if (abortReq) begin
                        Tx     <= 1'b0;
                        bitCnt <= 4'd1;
                        state  <= ABORT;
                    end else begin
                        Tx      <= FLAG_PAT[bitCnt[2:0]];
                        onesCnt <= '0;
                        if (bitCnt == 4'd7) begin
                            bitCnt <= '0;
                            state  <= DATA;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (abortReq) begin
                        Tx     <= 1'b0;
                        bitCnt <= 4'd1;
                        state  <= ABORT;
                    end else if (onesCnt == 3'd5) begin
                        Tx      <= 1'b0;
                        onesCnt <= '0;
                    end else begin
                        Tx      <= shReg[bitCnt[2:0]];
                        onesCnt <= shReg[bitCnt[2:0]] ? onesCnt + 3'd1 : 3'd0;
                        if (bitCnt == 4'd7) begin
                            bitCnt <= '0;
                            if (isLast) begin
                                state <= CLOSE_FLAG;
                            end else if (Tx_ByteCount >= 8'(MAX_FRAME_BYTES)) begin
                                Tx_Overflow <= 1'b1;
                                state       <= ABORT;
                            end else if (!Tx_Valid) begin
                                Tx_Underrun <= 1'b1;
                                state       <= ABORT;
                            end else begin
                                shReg        <= Tx_Data;
                                isLast       <= Tx_Last;
                                Tx_RdBuff    <= 1'b1;
                                Tx_ByteCount <= Tx_ByteCount + 8'd1;
                            end
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                end
                CLOSE_FLAG: begin
                    if (abortReq) begin
                        Tx     <= 1'b0;
                        bitCnt <= 4'd1;
                        state  <= ABORT;
                    end else if (onesCnt == 3'd5) begin
                        Tx      <= 1'b0;
                        onesCnt <= '0;
                    end else if (bitCnt == 4'd8) begin
                        Tx      <= 1'b1;
                        Tx_Done <= 1'b1;
                        gapCnt  <= GW'(1);
                        state   <= GAP;
                    end else begin
                        Tx      <= FLAG_PAT[bitCnt[2:0]];
                        onesCnt <= '0;
                        bitCnt  <= bitCnt + 4'd1;
                    end
                end
                ABORT: begin
                    if (bitCnt == 4'd8) begin
                        Tx              <= 1'b1;
                        Tx_AbortedTrans <= 1'b1;
                        gapCnt          <= GW'(1);
                        state           <= GAP;
                    end else begin
                        Tx     <= ABORT_PAT[bitCnt[2:0]];
                        bitCnt <= bitCnt + 4'd1;
                    end
                end
                GAP: begin
                    Tx <= 1'b1;
                    if (gapCnt == GW'(IDLE_BITS)) begin
                        Tx_Busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + GW'(1);
                    end
                end
                default: begin
                    Tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
